// File: rtl/sampled_debouncer_pkg.sv
// +----------------------------------------------------------------------------+
// | sampled_debouncer_pkg                                                      |
// | Shared constants and sizing helper for sample-strobe consumers.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package sampled_debouncer_pkg;

  localparam int DEFAULT_SAT_COUNT = 150;

  // Counter holds 0..sat-1, so a 1- or 2-sample filter still needs one bit.
  function automatic int cnt_width(input int sat);
    return (sat <= 2) ? 1 : $clog2(sat);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sampled_debouncer_channel.sv
// +----------------------------------------------------------------------------+
// | debounce_channel                                                           |
// | Single-bit optional synchronizer, streak counter and flip/edge strobes.   |
// | Optional macro: DEBOUNCE_SYNC_EN (2-flop input synchronizer).             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module debounce_channel #(
  parameter int SAT_COUNT = 150,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_pulse,
  input  logic glitchy,
  output logic debounced,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(SAT_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  logic                 w_sample;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_debounced;
  logic                 r_rise;
  logic                 r_fall;

`ifdef DEBOUNCE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= glitchy;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = glitchy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_debounced <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (sample_pulse) begin
        if (w_sample == r_debounced) begin
          // Any agreeing sample throws away a partial disagreement streak.
          r_cnt <= '0;
        end else if (r_cnt == C_CNT_MAX) begin
          r_debounced <= w_sample;
          r_cnt       <= '0;
          r_rise      <= w_sample;
          r_fall      <= ~w_sample;
        end else begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign debounced  = r_debounced;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

`default_nettype wire

// File: rtl/sampled_debouncer.sv
// +----------------------------------------------------------------------------+
// | sampled_debouncer                                                          |
// | WIDTH independent strobe-sampled debouncers with rise/fall strobes.       |
// | Optional macro: DEBOUNCE_SYNC_EN (adds 2-flop synchronizer per input).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sampled_debouncer
  import sampled_debouncer_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int SAT_COUNT = DEFAULT_SAT_COUNT,
  parameter int CNT_WIDTH = cnt_width(SAT_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_pulse,
  input  logic [WIDTH-1:0] glitchy,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_channel
    debounce_channel #(
      .SAT_COUNT (SAT_COUNT),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .sample_pulse (sample_pulse),
      .glitchy      (glitchy[gi]),
      .debounced    (debounced[gi]),
      .rise_pulse   (rise_pulse[gi]),
      .fall_pulse   (fall_pulse[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_sampled_debouncer.sv
// +----------------------------------------------------------------------------+
// | tb_sampled_debouncer                                                       |
// | Directed self-checking bench: SAT_COUNT=4 single channel, SAT_COUNT=1 x4. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sampled_debouncer;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       sp_a = 1'b0;
  logic [0:0] gl_a = 1'b0;
  logic [0:0] deb_a, rise_a, fall_a;

  logic       sp_b = 1'b1;
  logic [3:0] gl_b = 4'b0000;
  logic [3:0] deb_b, rise_b, fall_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sampled_debouncer #(.WIDTH(1), .SAT_COUNT(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .sample_pulse (sp_a),
    .glitchy      (gl_a),
    .debounced    (deb_a),
    .rise_pulse   (rise_a),
    .fall_pulse   (fall_a)
  );

  sampled_debouncer #(.WIDTH(4), .SAT_COUNT(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .sample_pulse (sp_b),
    .glitchy      (gl_b),
    .debounced    (deb_b),
    .rise_pulse   (rise_b),
    .fall_pulse   (fall_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobed edge; returns 1 time unit after that edge.
  task automatic strobe();
    sp_a = 1'b1;
    @(posedge clk);
    #1;
    sp_a = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic d, input logic r, input logic f);
    check(tag, {5'b0, deb_a, rise_a, fall_a}, {5'b0, d, r, f});
  endtask

  initial begin
    logic [6:0] bounce;
    bounce = 7'b1110111;

    // Reset state
    #1;
    check_a("reset_a", 1'b0, 1'b0, 1'b0);
    check("reset_b", {deb_b, rise_b | fall_b}, 8'h00);
    idle(2);
    rst = 1'b0;

    // Flip up
    gl_a = 1'b1;
    idle(4);
    for (int i = 1; i <= 3; i++) begin
      strobe();
      check_a($sformatf("up_s%0d", i), 1'b0, 1'b0, 1'b0);
      idle(4);
    end
    strobe();
    check_a("up_flip", 1'b1, 1'b1, 1'b0);
    idle(1);
    check_a("up_after", 1'b1, 1'b0, 1'b0);
    idle(3);

    // Flip down
    gl_a = 1'b0;
    idle(4);
    for (int i = 1; i <= 3; i++) begin
      strobe();
      check_a($sformatf("dn_s%0d", i), 1'b1, 1'b0, 1'b0);
      idle(4);
    end
    strobe();
    check_a("dn_flip", 1'b0, 1'b0, 1'b1);
    idle(1);
    check_a("dn_after", 1'b0, 1'b0, 1'b0);
    idle(3);

    // Bounce rejection: 1,1,1,0,1,1,1 never reaches four in a row; an 8th 1 does.
    for (int i = 0; i < 7; i++) begin
      gl_a = bounce[6-i];
      idle(4);
      strobe();
      check_a($sformatf("bounce_s%0d", i + 1), 1'b0, 1'b0, 1'b0);
    end
    gl_a = 1'b1;
    idle(4);
    strobe();
    check_a("bounce_flip", 1'b1, 1'b1, 1'b0);

    // Reset between edges while counting toward a fall: outputs clear at once.
    gl_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(4);
      strobe();
    end
    check_a("pre_rst_hold", 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_a("async_rst", 1'b0, 1'b0, 1'b0);
    idle(2);
    rst = 1'b0;

    // Reset mid-count toward a rise: streak of 3 must be discarded.
    gl_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(4);
      strobe();
    end
    check_a("mid_cnt3", 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
    for (int i = 1; i <= 3; i++) begin
      strobe();
      check_a($sformatf("post_rst_s%0d", i), 1'b0, 1'b0, 1'b0);
      idle(4);
    end
    strobe();
    check_a("post_rst_flip", 1'b1, 1'b1, 1'b0);

    // Strobe gating: drive back to 0, then toggle with no strobes.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      gl_a = ~gl_a;
      idle(1);
      if (i % 100 == 0 || i == 999)
        check_a($sformatf("gate_c%0d", i), 1'b0, 1'b0, 1'b0);
    end
    gl_a = 1'b1;
    idle(4);
    for (int i = 1; i <= 3; i++) begin
      strobe();
      check_a($sformatf("gate_s%0d", i), 1'b0, 1'b0, 1'b0);
      idle(4);
    end
    strobe();
    check_a("gate_flip", 1'b1, 1'b1, 1'b0);

    // SAT_COUNT=1, sample_pulse tied high, 4 channels.
    check("b_pre", {deb_b, rise_b | fall_b}, 8'h00);
    gl_b = 4'b1010;
    if (SYNC_LAT > 0) begin
      idle(SYNC_LAT);
      check("b_sync_wait", {deb_b, rise_b}, 8'h00);
    end
    idle(1);
    check("b_deb_1010", {4'b0, deb_b}, 8'h0A);
    check("b_rise_1010", {rise_b, fall_b}, 8'hA0);
    idle(1);
    check("b_after_1010", {deb_b, rise_b | fall_b}, 8'hA0);
    gl_b = 4'b0110;
    idle(SYNC_LAT + 1);
    check("b_deb_0110", {4'b0, deb_b}, 8'h06);
    check("b_edges_0110", {rise_b, fall_b}, 8'h48);
    idle(1);
    check("b_after_0110", {rise_b, fall_b}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
